plot_sink: RTL and testbench

Receiving end of the pixel-plot interface used by the sprite and blit controllers. It accepts `(x, y, colour)` plot requests through a valid/ready handshake and buffers them in a small FIFO. Each request is converted to a linear framebuffer address and issued as a one-cycle write strobe to the framebuffer RAM write port. A whole-screen clear sequencer shares the same write port, replacing the per-blit delete sweeps.

---
 rtl/plot_sink.sv | 149 ++++++++++++++
 tb/tb_plot_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/plot_sink.sv
// Pixel-plot sink: FIFO-buffered plot requests and a whole-screen clear sweep sharing the framebuffer write port.
// Optional: define PLOT_SINK_CLIP_EN to drop out-of-range plots and count them in drop_count.
module plot_sink #(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 240,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [8:0]  plot_x,
    input  logic [7:0]  plot_y,
    input  logic [2:0]  plot_colour,
    input  logic        plot_valid,
    output logic        plot_ready,
    input  logic        clear_req,
    input  logic [2:0]  clear_colour,
    output logic        clear_done,
    output logic [16:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        fb_we,
    output logic [7:0]  drop_count,
    output logic        busy
);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [16:0] LAST_ADDR = 17'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } plot_t;

    state_t        state, state_nx;
    plot_t         mem [FIFO_DEPTH];
    plot_t         head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    logic [16:0]   sweep, head_addr;
    logic [2:0]    fill_colour;
    logic          last_wr;
    logic          wr_en;
    logic [16:0]   wr_addr;
    logic [2:0]    wr_data;

    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign empty      = (count == '0);
    // Ready depends only on registered state, so a full FIFO never accepts even while popping.
    assign plot_ready = !full && (state != DRAIN);
    assign push       = plot_valid && plot_ready;
    assign pop        = !empty && (state != CLEAR);
    assign head       = mem[rd_ptr];
    assign busy       = !empty || (state != IDLE);

    if (WIDTH == 320) begin : g_addr_320
        assign head_addr = ({9'b0, head.y} << 8) + ({9'b0, head.y} << 6) + {8'b0, head.x};
    end else begin : g_addr_gen
        assign head_addr = 17'(head.y) * 17'(WIDTH) + 17'(head.x);
    end

`ifdef PLOT_SINK_CLIP_EN
    logic in_range;
    logic drop;
    assign in_range = ({23'b0, head.x} < 32'(WIDTH)) && ({24'b0, head.y} < 32'(HEIGHT));
    assign drop     = pop && !in_range;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clear_req) state_nx = DRAIN;
            // With count==1 the pop this cycle empties the FIFO, so DRAIN lasts exactly the occupancy.
            DRAIN:   if (count <= (PW+1)'(1)) state_nx = CLEAR;
            CLEAR:   if (sweep == LAST_ADDR) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = fb_addr;
        wr_data = fb_data;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = sweep;
            wr_data = fill_colour;
        end else if (pop) begin
`ifdef PLOT_SINK_CLIP_EN
            if (in_range) begin
                wr_en   = 1'b1;
                wr_addr = head_addr;
                wr_data = head.c;
            end
`else
            wr_en   = 1'b1;
            wr_addr = head_addr;
            wr_data = head.c;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {plot_x, plot_y, plot_colour};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            sweep       <= '0;
            fill_colour <= '0;
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_data     <= '0;
            last_wr     <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (state == IDLE && clear_req) fill_colour <= clear_colour;
            sweep      <= (state == CLEAR) ? sweep + 1'b1 : '0;
            fb_we      <= wr_en;
            fb_addr    <= wr_addr;
            fb_data    <= wr_data;
            last_wr    <= (state == CLEAR) && (sweep == LAST_ADDR);
            clear_done <= last_wr;
        end
    end

`ifdef PLOT_SINK_CLIP_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          drop_count <= '0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_plot_sink.sv
// Directed self-checking bench for plot_sink: reset, single plot, burst, range handling, clear sweep, reset mid-sweep.
module tb_plot_sink;
    logic        clk = 1'b0;
    logic        resetn;
    logic [8:0]  plot_x;
    logic [7:0]  plot_y;
    logic [2:0]  plot_colour;
    logic        plot_valid;
    logic        plot_ready;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        clear_done;
    logic [16:0] fb_addr;
    logic [2:0]  fb_data;
    logic        fb_we;
    logic [7:0]  drop_count;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    plot_sink #(.WIDTH(320), .HEIGHT(240), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
        .plot_valid(plot_valid), .plot_ready(plot_ready),
        .clear_req(clear_req), .clear_colour(clear_colour), .clear_done(clear_done),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we),
        .drop_count(drop_count), .busy(busy)
    );

    always #10 clk = ~clk;

    task automatic test_reset();
        resetn = 1'b0; plot_x = '0; plot_y = '0; plot_colour = '0; plot_valid = 1'b0;
        clear_req = 1'b0; clear_colour = '0;
        repeat (3) @(negedge clk);
        checks++; if (plot_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", plot_ready); end
        checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", fb_we); end
        checks++; if (fb_addr !== 17'd0 || fb_data !== 3'd0) begin failures++; $display("FAIL reset_fb got=%0d/%0d exp=0/0", fb_addr, fb_data); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", drop_count); end
        checks++; if (busy !== 1'b0 || clear_done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, clear_done); end
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if ({plot_ready, fb_we, busy} !== 3'b100) begin failures++; $display("FAIL post_reset_idle got=%b exp=100", {plot_ready, fb_we, busy}); end
    endtask

    task automatic test_single();
        plot_x = 9'd10; plot_y = 8'd5; plot_colour = 3'b101; plot_valid = 1'b1;
        checks++; if (plot_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", plot_ready); end
        @(negedge clk);
        plot_valid = 1'b0;
        checks++; if (fb_we !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL single_early got=we%b busy%b exp=we0 busy1", fb_we, busy); end
        @(negedge clk);
        checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, 17'd1610, 3'b101}) begin
            failures++; $display("FAIL single_write got=we%b addr%0d data%b exp=we1 addr1610 data101", fb_we, fb_addr, fb_data); end
        @(negedge clk);
        checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_once got=we%b busy%b exp=we0 busy0", fb_we, busy); end
    endtask

    task automatic test_back_to_back();
        logic [16:0] ea;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 9) begin
                ea = 17'(76480 + c - 2);
                checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, ea, 3'(c - 2)}) begin
                    failures++; $display("FAIL burst_write[%0d] got=we%b addr%0d data%0d exp=we1 addr%0d data%0d", c - 2, fb_we, fb_addr, fb_data, ea, c - 2); end
            end else begin
                checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL burst_idle[%0d] got=%b exp=0", c, fb_we); end
            end
            if (c < 8) begin
                checks++; if (plot_ready !== 1'b1) begin failures++; $display("FAIL burst_ready[%0d] got=%b exp=1", c, plot_ready); end
                plot_x = 9'(c); plot_y = 8'd239; plot_colour = 3'(c); plot_valid = 1'b1;
            end else begin
                plot_valid = 1'b0;
            end
        end
    endtask

    task automatic test_range();
`ifdef PLOT_SINK_CLIP_EN
        int we_seen;
        we_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (fb_we) we_seen++;
            if (c == 0)      begin plot_x = 9'd320; plot_y = 8'd0;   plot_valid = 1'b1; end
            else if (c == 1) begin plot_x = 9'd0;   plot_y = 8'd240; end
            else               plot_valid = 1'b0;
        end
        checks++; if (we_seen !== 0) begin failures++; $display("FAIL clip_no_write got=%0d exp=0", we_seen); end
        checks++; if (drop_count !== 8'd2) begin failures++; $display("FAIL clip_drop2 got=%0d exp=2", drop_count); end
        for (int c = 0; c < 305; c++) begin
            @(negedge clk);
            if (fb_we) we_seen++;
            plot_x = 9'd500; plot_y = 8'd7; plot_valid = (c < 300);
        end
        checks++; if (we_seen !== 0) begin failures++; $display("FAIL clip_sat_no_write got=%0d exp=0", we_seen); end
        checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL clip_saturate got=%0d exp=255", drop_count); end
        plot_x = 9'd319; plot_y = 8'd239; plot_colour = 3'b010; plot_valid = 1'b1;
        @(negedge clk);
        plot_valid = 1'b0;
        @(negedge clk);
        checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, 17'd76799, 3'b010}) begin
            failures++; $display("FAIL clip_edge_write got=we%b addr%0d data%b exp=we1 addr76799 data010", fb_we, fb_addr, fb_data); end
`else
        logic [16:0] ea [3];
        logic [2:0]  ed [3];
        ea[0] = 17'd320;   ed[0] = 3'b111;
        ea[1] = 17'd76799; ed[1] = 3'b010;
        ea[2] = 17'd82111; ed[2] = 3'b001;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 4) begin
                checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, ea[c-2], ed[c-2]}) begin
                    failures++; $display("FAIL range_write[%0d] got=we%b addr%0d data%b exp=we1 addr%0d data%b", c - 2, fb_we, fb_addr, fb_data, ea[c-2], ed[c-2]); end
            end
            case (c)
                0:       begin plot_x = 9'd320; plot_y = 8'd0;   plot_colour = 3'b111; plot_valid = 1'b1; end
                1:       begin plot_x = 9'd319; plot_y = 8'd239; plot_colour = 3'b010; end
                2:       begin plot_x = 9'd511; plot_y = 8'd255; plot_colour = 3'b001; end
                default: plot_valid = 1'b0;
            endcase
        end
        checks++; if (fb_we !== 1'b0) begin failures++; $display("FAIL range_idle got=%b exp=0", fb_we); end
        checks++; if (drop_count !== 8'd0) begin failures++; $display("FAIL range_drop got=%0d exp=0", drop_count); end
`endif
    endtask

    // Writes are contiguous from the cycle after clear_req: write number e appears at loop cycle e.
    task automatic test_clear();
        int e, bad, dones, done_c;
        logic [16:0] ea;
        logic [2:0]  ed;
        e = 0; bad = 0; dones = 0; done_c = -1;
        @(negedge clk);
        plot_x = 9'd3; plot_y = 8'd2; plot_colour = 3'b011; plot_valid = 1'b1;
        @(negedge clk);
        plot_x = 9'd4; plot_colour = 3'b100; clear_req = 1'b1; clear_colour = 3'b001;
        @(negedge clk);
        plot_valid = 1'b0; clear_req = 1'b0; clear_colour = 3'b111;
        checks++; if (plot_ready !== 1'b0) begin failures++; $display("FAIL clear_drain_ready got=%b exp=0", plot_ready); end
        for (int cyc = 0; cyc < 80000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (fb_we) begin
                if (e < 2) begin
                    ea = (e == 0) ? 17'd643 : 17'd644;
                    ed = (e == 0) ? 3'b011 : 3'b100;
                    checks++; if ({fb_addr, fb_data} !== {ea, ed} || cyc != e) begin
                        failures++; $display("FAIL clear_pre_plot[%0d] got=addr%0d data%b cyc%0d exp=addr%0d data%b cyc%0d", e, fb_addr, fb_data, cyc, ea, ed, e); end
                end else if (e < 76802) begin
                    if (fb_addr !== 17'(e - 2) || fb_data !== 3'b001 || cyc != e) bad++;
                end else if (e < 76806) begin
                    ea = 17'(320 + e - 76802);
                    checks++; if ({fb_addr, fb_data} !== {ea, 3'b010} || cyc != e) begin
                        failures++; $display("FAIL clear_post_plot[%0d] got=addr%0d data%b cyc%0d exp=addr%0d data010 cyc%0d", e - 76802, fb_addr, fb_data, cyc, ea, e); end
                end
                e++;
            end
            if (clear_done) begin dones++; done_c = cyc; end
            if (cyc >= 100 && cyc <= 104) begin
                checks++; if (plot_ready !== (cyc < 104)) begin
                    failures++; $display("FAIL clear_offer_ready[%0d] got=%b exp=%b", cyc - 100, plot_ready, (cyc < 104)); end
                plot_x = 9'(cyc - 100); plot_y = 8'd1; plot_colour = 3'b010; plot_valid = 1'b1;
            end else begin
                plot_valid = 1'b0;
            end
            if (done_c >= 0 && cyc >= done_c + 10) break;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL clear_sweep got=%0d bad writes exp=0", bad); end
        checks++; if (e !== 76806) begin failures++; $display("FAIL clear_write_count got=%0d exp=76806", e); end
        checks++; if (dones !== 1) begin failures++; $display("FAIL clear_done_count got=%0d exp=1", dones); end
        checks++; if (done_c !== 76802) begin failures++; $display("FAIL clear_done_cycle got=%0d exp=76802", done_c); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clear_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        @(negedge clk);
        clear_req = 1'b1; clear_colour = 3'b101;
        @(negedge clk);
        clear_req = 1'b0;
        for (int cyc = 0; cyc < 1000 && !found; cyc++) begin
            @(negedge clk);
            plot_x = 9'd9; plot_y = 8'd9; plot_colour = 3'b011;
            plot_valid = (cyc == 50 || cyc == 51);
            if (fb_we && fb_addr == 17'd400) found = 1'b1;
        end
        plot_valid = 1'b0;
        checks++; if (!found) begin failures++; $display("FAIL rst_mid_reach got=timeout exp=addr400"); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mid_prebusy got=%b exp=1", busy); end
        #2 resetn = 1'b0;
        #1;
        checks++; if ({fb_we, busy, plot_ready, clear_done} !== 4'b0010) begin
            failures++; $display("FAIL rst_mid_async got=we%b busy%b ready%b done%b exp=we0 busy0 ready1 done0", fb_we, busy, plot_ready, clear_done); end
        checks++; if (fb_addr !== 17'd0 || fb_data !== 3'd0) begin failures++; $display("FAIL rst_mid_fb got=%0d/%0d exp=0/0", fb_addr, fb_data); end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (fb_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_flushed got=we%b busy%b exp=we0 busy0", fb_we, busy); end
        end
        plot_x = 9'd0; plot_y = 8'd0; plot_colour = 3'b110; plot_valid = 1'b1;
        @(negedge clk);
        plot_valid = 1'b0;
        @(negedge clk);
        checks++; if ({fb_we, fb_addr, fb_data} !== {1'b1, 17'd0, 3'b110}) begin
            failures++; $display("FAIL rst_mid_plot got=we%b addr%0d data%b exp=we1 addr0 data110", fb_we, fb_addr, fb_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_range();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
